// File: rtl/parca_besleyici_if.sv
// Piece feeder bus: write side, start command and the stream
// toward the tetris scoring stage.
interface parca_besleyici_if #(
    parameter int GENISLIK = 3
);
    logic                yaz;
    logic [GENISLIK-1:0] yaz_parca;
    logic                hazir_yaz;
    logic                basla;
    logic [GENISLIK-1:0] parca;
    logic                akis;
    logic [4:0]          sayac;
    logic                tamam;
    logic                hata;

    modport master (
        output yaz, yaz_parca, basla,
        input  hazir_yaz, parca, akis, sayac, tamam, hata
    );

    modport slave (
        input  yaz, yaz_parca, basla,
        output hazir_yaz, parca, akis, sayac, tamam, hata
    );
endinterface

// File: rtl/parca_besleyici.sv
// Buffers one game of pieces, then streams them one per clock
// to the tetris scoring stage on a start command.
module parca_besleyici #(
    parameter int DERINLIK = 16,
    parameter int GENISLIK = 3
) (
    input logic clk,
    input logic rst,
    parca_besleyici_if.slave bus
);
    localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        YUKLE,
        HAZIR,
        AKIS,
        SON
    } durum_t;

    durum_t durum, durum_n;

    logic [GENISLIK-1:0] mem [DERINLIK];
    logic [CW-1:0]       wcount;
    logic [CW-1:0]       rptr;
    logic                yaz_ok;
    logic                son_parca;

    assign yaz_ok       = bus.yaz && (durum == YUKLE);
    assign son_parca    = (bus.sayac == 5'(DERINLIK));
    assign bus.hazir_yaz = (durum == YUKLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) durum <= YUKLE;
        else     durum <= durum_n;
    end

    always_comb begin
        durum_n = durum;
        unique case (durum)
            YUKLE: if (yaz_ok && wcount == CW'(DERINLIK - 1))
                       durum_n = HAZIR;
            HAZIR: if (bus.basla) durum_n = AKIS;
            AKIS:  if (son_parca) durum_n = SON;
            SON:   durum_n = YUKLE;
            default: durum_n = YUKLE;
        endcase
    end

    // Buffer contents need no reset; wcount gates every read.
    always_ff @(posedge clk) begin
        if (yaz_ok) mem[wcount[AW-1:0]] <= bus.yaz_parca;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcount    <= '0;
            rptr      <= '0;
            bus.parca <= '0;
            bus.akis  <= 1'b0;
            bus.sayac <= '0;
            bus.tamam <= 1'b0;
            bus.hata  <= 1'b0;
        end else begin
            bus.parca <= '0;
            bus.akis  <= 1'b0;
            bus.tamam <= 1'b0;
            bus.hata  <= bus.hata
                       | (bus.yaz && durum != YUKLE)
                       | (bus.basla && durum != HAZIR);
            unique case (durum)
                YUKLE: if (yaz_ok) wcount <= wcount + 1'b1;
                HAZIR: if (bus.basla) begin
                    bus.parca <= mem[0];
                    bus.akis  <= 1'b1;
                    bus.sayac <= 5'd1;
                    rptr      <= CW'(1);
                end
                AKIS: if (son_parca) begin
                    bus.tamam <= 1'b1;
                end else begin
                    bus.parca <= mem[rptr[AW-1:0]];
                    bus.akis  <= 1'b1;
                    bus.sayac <= bus.sayac + 5'd1;
                    rptr      <= rptr + 1'b1;
                end
                SON: begin
                    bus.sayac <= '0;
                    wcount    <= '0;
                    rptr      <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/parca_besleyici.md
Name: parca_besleyici

Overview:
Upstream piece feeder for the tetris scoring stage. It buffers one game of pieces (DERINLIK 3-bit column masks) written one at a time. On a start command it streams them back-to-back, one per clock, on the parca bus the tetris stage samples every cycle. Outside a stream it drives parca = 0, so extra downstream cycles add no height.

Parameters:
DERINLIK, 16, pieces per game; power of two, 2..16
GENISLIK, 3, piece width = number of board columns

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
yaz  input  1  write strobe, one piece per cycle
yaz_parca  input  GENISLIK  piece to store; any value legal, including 0
hazir_yaz  output  1  1 = a write this cycle is accepted
basla  input  1  start streaming the stored game
parca  output  GENISLIK  piece to tetris stage, registered
akis  output  1  1 while parca carries a valid piece
sayac  output  5  pieces presented so far in current stream
tamam  output  1  one-cycle pulse after the last piece
hata  output  1  sticky protocol-error flag

Behaviour:
- One clock; reset is asynchronous and active-high, ports clk / rst.
- While rst is high: state YUKLE, write count 0, read pointer 0, parca 0, akis 0, sayac 0, tamam 0, hata 0, hazir_yaz 1. Buffer contents are don't-care.
- States: YUKLE, HAZIR, AKIS, SON. All outputs are registered except hazir_yaz = (state == YUKLE).
- YUKLE: yaz=1 stores yaz_parca at buf[wcount] and increments wcount. When the write makes wcount == DERINLIK, the next state is HAZIR. Pieces keep write order.
- HAZIR: waits for basla. On the edge sampling basla=1:
  - state goes to AKIS
  - parca <= buf[0], akis <= 1, sayac <= 1
  - Latency: first piece is visible in the cycle after basla is sampled.
- AKIS: each edge presents the next piece, parca <= buf[rptr] and sayac <= sayac+1. akis stays 1 for exactly DERINLIK consecutive cycles with no gaps.
- Edge after the last piece (sayac == DERINLIK):
  - parca <= 0, akis <= 0, tamam <= 1, state goes to SON
  - sayac holds DERINLIK
- SON: lasts one cycle. Next edge: tamam <= 0, sayac <= 0, wcount/rptr <= 0, state goes to YUKLE.
- Errors (hata <= 1, cleared only by rst):
  - yaz=1 while hazir_yaz=0: write ignored.
  - basla=1 in any state other than HAZIR: ignored, no state change.
- Simultaneous yaz and basla in YUKLE: the write is accepted normally and basla flags hata, even if the write completes the game. The game then waits in HAZIR for a new basla.
- Width rules: wcount/rptr are wide enough to hold DERINLIK without wrap. sayac never exceeds DERINLIK and never wraps.
- Reset mid-operation: asynchronous return to the reset values above, from any state, including mid-stream. The partial stream is abandoned and the next game starts from an empty buffer.
- parca is 0 in every cycle where akis = 0.

Test Plan:
1. Load pattern 1: reset, write 1,2,3,4,5,6,7,0 repeated twice (16 writes).
   - hazir_yaz = 0 after the 16th write.
   - basla gives parca = 1,2,...,7,0,1,...,0 on 16 consecutive cycles with akis = 1 and sayac = 1..16.
   - Next cycle: parca = 0, tamam = 1. Cycle after: tamam = 0, sayac = 0, hazir_yaz = 1.
2. Single column: 16 × 3'b001, stream into the tetris stage → column-0 height 16, others 0. parca stays 0 after the stream.
3. Extra write: 17th write while HAZIR → hata = 1, then basla → stream identical to the 16 stored pieces.
4. Early start: basla after 10 writes → hata = 1, no stream. 6 more writes, then basla → normal 16-piece stream.
5. Reset mid-stream: rst at the 8th streamed piece → immediately parca = 0, akis = 0, sayac = 0, hazir_yaz = 1, hata = 0. A fresh load/stream then completes normally.
6. Back-to-back games: after tamam, load game B (16 × 3'b110) and stream → correct B sequence, with no residue from game A.
